// File: rtl/dma_master_mem_slave_bus.sv
// dma_master_mem_slave_bus
//   One DMA master and one word-addressed memory slave joined by an internal
//   AXI-style channel set (AW/W/B, AR/R). The CPU/cache side issues two kinds
//   of level-handshake requests:
//     - page-fault fill : burst read from memory, streamed out on dma_rd_*
//     - cache write-back: burst write into memory, streamed in on dma_wr_*
//   Each request raises a sticky done flag that clears one edge after its
//   happen input is seen low.
//
// Ports
//   cpu_clk, cpu_rst                       clock, synchronous active-high reset
//   dma_page_fault_happen/_addr/_burst_len fill request (beats = burst_len+1)
//   dma_page_fault_done                    fill complete (sticky)
//   dma_write_back_happen/_addr/_burst_len write-back request (beats = burst_len+1)
//   dma_write_back_done                    write-back complete (sticky)
//   dma_wr_data, dma_wr_ready              write beat data; sampled on edges where ready=1
//   dma_rd_data, dma_rd_valid              fill beat data, valid one cycle per beat
//   dma_beat_count                         only with DMA_BEAT_COUNT_EN: saturating count
//                                          of W beats written plus R beats delivered
//
// Build option
//   `define DMA_BEAT_COUNT_EN to add the dma_beat_count output and its counter.
module dma_master_mem_slave_bus #(
  parameter int ADDR_WIDTH           = 32,
  parameter int READ_CHANNEL_WIDTH   = 32,
  parameter int READ_BURST_LEN       = 8,
  parameter int WRITE_CHANNEL_WIDTH  = 32,
  parameter int WRITE_BURST_LEN      = 8,
  parameter int ASYNCFIFO_ADDR_WIDTH = 3,
  parameter int MEM_DEPTH_LOG2       = 10
) (
  input  logic                           cpu_clk,
  input  logic                           cpu_rst,
  input  logic                           dma_page_fault_happen,
  output logic                           dma_page_fault_done,
  input  logic [ADDR_WIDTH-1:0]          dma_page_fault_addr,
  input  logic [READ_BURST_LEN-1:0]      dma_page_fault_burst_len,
  input  logic                           dma_write_back_happen,
  output logic                           dma_write_back_done,
  input  logic [ADDR_WIDTH-1:0]          dma_write_back_addr,
  input  logic [WRITE_BURST_LEN-1:0]     dma_write_back_burst_len,
  input  logic [WRITE_CHANNEL_WIDTH-1:0] dma_wr_data,
  output logic                           dma_wr_ready,
  output logic [READ_CHANNEL_WIDTH-1:0]  dma_rd_data,
  output logic                           dma_rd_valid
`ifdef DMA_BEAT_COUNT_EN
  ,
  output logic [31:0]                    dma_beat_count
`endif
);

  localparam int MEM_DEPTH  = 1 << MEM_DEPTH_LOG2;
  localparam int FIFO_DEPTH = 1 << ASYNCFIFO_ADDR_WIDTH;
  localparam logic [ASYNCFIFO_ADDR_WIDTH:0] FIFO_FULL = FIFO_DEPTH[ASYNCFIFO_ADDR_WIDTH:0];
  localparam logic [1:0] RESP_OKAY = 2'b00;

  typedef enum logic [2:0] {
    IDLE, WR_ADDR, WR_DATA, WR_RESP, RD_ADDR, RD_DATA, DONE_WR, DONE_RD
  } state_t;

  // ---------------------------------------------------------------- master regs
  state_t                          state_reg;
  logic [MEM_DEPTH_LOG2-1:0]       req_addr_reg;   // only the memory index bits matter
  logic [WRITE_BURST_LEN-1:0]      wr_len_reg;
  logic [READ_BURST_LEN-1:0]       rd_len_reg;
  logic [WRITE_BURST_LEN:0]        push_rem_reg;   // beats still to take from dma_wr_data
  logic [WRITE_BURST_LEN:0]        push_rem_next;
  logic                            rd_tail_reg;    // last R beat was just presented

  // Upper address bits wrap away; keep them visibly consumed.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{dma_write_back_addr[ADDR_WIDTH-1:MEM_DEPTH_LOG2],
                              dma_page_fault_addr[ADDR_WIDTH-1:MEM_DEPTH_LOG2]};

  // ---------------------------------------------------------------- channels
  logic aw_valid, ar_valid, b_ready;
  assign aw_valid = (state_reg == WR_ADDR);
  assign ar_valid = (state_reg == RD_ADDR);
  assign b_ready  = (state_reg == WR_RESP);

  // ---------------------------------------------------------------- W FIFO
  logic [WRITE_CHANNEL_WIDTH-1:0]  fifo_mem [FIFO_DEPTH];
  logic [ASYNCFIFO_ADDR_WIDTH-1:0] fifo_wptr_reg, fifo_rptr_reg;
  logic [ASYNCFIFO_ADDR_WIDTH:0]   fifo_count_reg, fifo_count_next;
  logic                            w_push, w_pop;

  // The registered ready is the push strobe: data is taken on every edge it is high.
  assign w_push = dma_wr_ready;
  // The slave drains one entry per cycle whenever anything is queued.
  assign w_pop  = (fifo_count_reg != '0);

  always_comb begin
    fifo_count_next = fifo_count_reg;
    case ({w_push, w_pop})
      2'b10:   fifo_count_next = fifo_count_reg + 1'b1;
      2'b01:   fifo_count_next = fifo_count_reg - 1'b1;
      default: fifo_count_next = fifo_count_reg;
    endcase
  end

  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) begin
      fifo_wptr_reg  <= '0;
      fifo_rptr_reg  <= '0;
      fifo_count_reg <= '0;
    end else begin
      if (w_push) fifo_wptr_reg <= fifo_wptr_reg + 1'b1;
      if (w_pop)  fifo_rptr_reg <= fifo_rptr_reg + 1'b1;
      fifo_count_reg <= fifo_count_next;
    end
  end

  always_ff @(posedge cpu_clk) begin
    if (w_push && !cpu_rst) fifo_mem[fifo_wptr_reg] <= dma_wr_data;
  end

  // ---------------------------------------------------------------- slave write side
  logic [MEM_DEPTH_LOG2-1:0]  wr_ptr_reg;
  logic [WRITE_BURST_LEN-1:0] wr_rem_reg;
  logic                       b_valid_reg;
  logic [1:0]                 b_resp_reg;
  logic                       w_last;
  logic                       mem_we;

  assign w_last = w_pop && (wr_rem_reg == '0);
  // A reset edge must not commit a half-delivered beat.
  assign mem_we = w_pop && !cpu_rst;

  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) begin
      wr_ptr_reg  <= '0;
      wr_rem_reg  <= '0;
      b_valid_reg <= 1'b0;
      b_resp_reg  <= RESP_OKAY;
    end else begin
      if (aw_valid) begin
        wr_ptr_reg <= req_addr_reg;
        wr_rem_reg <= wr_len_reg;
      end else if (w_pop) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;   // wraps modulo memory depth
        wr_rem_reg <= wr_rem_reg - 1'b1;
      end
      if (w_last) begin
        b_valid_reg <= 1'b1;
        b_resp_reg  <= RESP_OKAY;
      end else if (b_valid_reg && b_ready) begin
        b_valid_reg <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------- slave read side
  logic [MEM_DEPTH_LOG2-1:0]     rd_ptr_reg;
  logic [READ_BURST_LEN-1:0]     rd_rem_reg;
  logic                          rd_active_reg;
  logic                          r_valid_reg, r_last_reg;
  logic [READ_CHANNEL_WIDTH-1:0] r_data_reg;

  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) begin
      rd_ptr_reg    <= '0;
      rd_rem_reg    <= '0;
      rd_active_reg <= 1'b0;
      r_valid_reg   <= 1'b0;
      r_last_reg    <= 1'b0;
    end else begin
      r_valid_reg <= 1'b0;
      r_last_reg  <= 1'b0;
      if (ar_valid) begin
        rd_ptr_reg    <= req_addr_reg;
        rd_rem_reg    <= rd_len_reg;
        rd_active_reg <= 1'b1;
      end else if (rd_active_reg) begin
        // r_data_reg captures mem[rd_ptr_reg] on this same edge, so valid lines up.
        r_valid_reg <= 1'b1;
        r_last_reg  <= (rd_rem_reg == '0);
        rd_ptr_reg  <= rd_ptr_reg + 1'b1;
        rd_rem_reg  <= rd_rem_reg - 1'b1;
        if (rd_rem_reg == '0) rd_active_reg <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------- memory (not reset)
  logic [WRITE_CHANNEL_WIDTH-1:0] mem [MEM_DEPTH];

  always_ff @(posedge cpu_clk) begin
    if (mem_we) mem[wr_ptr_reg] <= fifo_mem[fifo_rptr_reg];
    r_data_reg <= READ_CHANNEL_WIDTH'(mem[rd_ptr_reg]);
  end

  // ---------------------------------------------------------------- master FSM
  always_comb begin
    push_rem_next = w_push ? (push_rem_reg - 1'b1) : push_rem_reg;
  end

  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) begin
      state_reg           <= IDLE;
      req_addr_reg        <= '0;
      wr_len_reg          <= '0;
      rd_len_reg          <= '0;
      push_rem_reg        <= '0;
      rd_tail_reg         <= 1'b0;
      dma_write_back_done <= 1'b0;
      dma_page_fault_done <= 1'b0;
      dma_wr_ready        <= 1'b0;
      dma_rd_valid        <= 1'b0;
      dma_rd_data         <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          dma_wr_ready <= 1'b0;
          dma_rd_valid <= 1'b0;
          // Write-back wins a tie so a later fill always sees the evicted data.
          if (dma_write_back_happen) begin
            req_addr_reg <= dma_write_back_addr[MEM_DEPTH_LOG2-1:0];
            wr_len_reg   <= dma_write_back_burst_len;
            push_rem_reg <= {1'b0, dma_write_back_burst_len} + 1'b1;
            state_reg    <= WR_ADDR;
          end else if (dma_page_fault_happen) begin
            req_addr_reg <= dma_page_fault_addr[MEM_DEPTH_LOG2-1:0];
            rd_len_reg   <= dma_page_fault_burst_len;
            state_reg    <= RD_ADDR;
          end
        end
        WR_ADDR, WR_DATA: begin
          push_rem_reg <= push_rem_next;
          dma_wr_ready <= (push_rem_next != '0) && (fifo_count_next < FIFO_FULL);
          if (state_reg == WR_ADDR) state_reg <= WR_DATA;
          else if (w_last)          state_reg <= WR_RESP;
        end
        WR_RESP: begin
          dma_wr_ready <= 1'b0;
          if (b_valid_reg && b_resp_reg == RESP_OKAY) begin
            dma_write_back_done <= 1'b1;
            state_reg           <= DONE_WR;
          end
        end
        RD_ADDR: begin
          rd_tail_reg <= 1'b0;
          state_reg   <= RD_DATA;
        end
        RD_DATA: begin
          dma_rd_valid <= r_valid_reg;
          if (r_valid_reg) dma_rd_data <= r_data_reg;
          rd_tail_reg <= r_valid_reg && r_last_reg;
          if (rd_tail_reg) begin
            dma_page_fault_done <= 1'b1;
            state_reg           <= DONE_RD;
          end
        end
        DONE_WR: begin
          if (!dma_write_back_happen) begin
            dma_write_back_done <= 1'b0;
            state_reg           <= IDLE;
          end
        end
        DONE_RD: begin
          if (!dma_page_fault_happen) begin
            dma_page_fault_done <= 1'b0;
            state_reg           <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

`ifdef DMA_BEAT_COUNT_EN
  // ---------------------------------------------------------------- beat counter
  logic       r_beat;
  logic [1:0] beat_inc;
  logic [32:0] beat_sum;

  assign r_beat   = (state_reg == RD_DATA) && r_valid_reg;
  assign beat_inc = {1'b0, w_pop} + {1'b0, r_beat};
  assign beat_sum = {1'b0, dma_beat_count} + {31'd0, beat_inc};

  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) begin
      dma_beat_count <= '0;
    end else begin
      dma_beat_count <= beat_sum[32] ? '1 : beat_sum[31:0];
    end
  end
`endif

endmodule

// File: tb/tb_dma_master_mem_slave_bus.sv
// Self-checking bench for dma_master_mem_slave_bus. A word-array model of the
// memory tracks every write-back; fills are compared against it, and done
// latencies against the beats+3 rule.
module tb_dma_master_mem_slave_bus;

  logic        clk = 1'b0;
  logic        rst;
  logic        pf_happen, pf_done;
  logic [31:0] pf_addr;
  logic [7:0]  pf_len;
  logic        wb_happen, wb_done;
  logic [31:0] wb_addr;
  logic [7:0]  wb_len;
  logic [31:0] wr_data;
  logic        wr_ready;
  logic [31:0] rd_data;
  logic        rd_valid;
`ifdef DMA_BEAT_COUNT_EN
  logic [31:0] beat_count;
`endif

  dma_master_mem_slave_bus dut (
    .cpu_clk                  (clk),
    .cpu_rst                  (rst),
    .dma_page_fault_happen    (pf_happen),
    .dma_page_fault_done      (pf_done),
    .dma_page_fault_addr      (pf_addr),
    .dma_page_fault_burst_len (pf_len),
    .dma_write_back_happen    (wb_happen),
    .dma_write_back_done      (wb_done),
    .dma_write_back_addr      (wb_addr),
    .dma_write_back_burst_len (wb_len),
    .dma_wr_data              (wr_data),
    .dma_wr_ready             (wr_ready),
    .dma_rd_data              (rd_data),
    .dma_rd_valid             (rd_valid)
`ifdef DMA_BEAT_COUNT_EN
    ,
    .dma_beat_count           (beat_count)
`endif
  );

  always #5 clk = ~clk;

  int cycle_cnt = 0;
  always @(posedge clk) cycle_cnt++;

  int checks = 0;
  int errors = 0;

  logic [31:0] ref_mem [0:1023];
  logic [31:0] wdata [0:255];
  logic [31:0] rq [$];

  // ---------------------------------------------------------------- drivers
  // Write-back: returns beats taken, done latency from acceptance edge,
  // whether done stayed high while happen held, and whether it cleared.
  task automatic do_write(input logic [31:0] a, input int len,
                          output int beats, output int lat,
                          output bit held, output bit cleared);
    int acc;
    beats = 0;
    lat = -1;
    @(negedge clk);
    wb_addr = a;
    wb_len = len[7:0];
    wb_happen = 1'b1;
    acc = cycle_cnt + 1;
    for (int k = 0; k < 700; k++) begin
      @(negedge clk);
      if (k == 0) begin
        wb_addr = $urandom;   // must be ignored after acceptance
        wb_len = 8'($urandom);
      end
      if (wb_done) begin
        lat = cycle_cnt - acc;
        break;
      end
      wr_data = wdata[beats & 255];
      if (wr_ready) beats++;
    end
    held = 1'b1;
    repeat (2) begin
      @(negedge clk);
      if (!wb_done || wr_ready) held = 1'b0;
    end
    wb_happen = 1'b0;
    @(negedge clk);
    cleared = !wb_done;
    for (int i = 0; i <= len; i++) ref_mem[(a + i) % 1024] = wdata[i];
  endtask

  // Page fault: beats land in rq.
  task automatic do_read(input logic [31:0] a, input int len,
                         output int lat, output bit held, output bit cleared);
    int acc;
    lat = -1;
    rq.delete();
    @(negedge clk);
    pf_addr = a;
    pf_len = len[7:0];
    pf_happen = 1'b1;
    acc = cycle_cnt + 1;
    for (int k = 0; k < 700; k++) begin
      @(negedge clk);
      if (k == 0) begin
        pf_addr = $urandom;
        pf_len = 8'($urandom);
      end
      if (rd_valid) rq.push_back(rd_data);
      if (pf_done) begin
        lat = cycle_cnt - acc;
        break;
      end
    end
    held = 1'b1;
    repeat (2) begin
      @(negedge clk);
      if (!pf_done || rd_valid) held = 1'b0;
    end
    pf_happen = 1'b0;
    @(negedge clk);
    cleared = !pf_done;
  endtask

  // ---------------------------------------------------------------- scenarios
  task automatic test_reset();
    rst = 1'b1;
    pf_happen = 0; wb_happen = 0; pf_addr = 0; pf_len = 0;
    wb_addr = 0; wb_len = 0; wr_data = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (wb_done !== 1'b0) begin errors++; $display("FAIL reset_wb_done got %b exp 0", wb_done); end
    checks++; if (pf_done !== 1'b0) begin errors++; $display("FAIL reset_pf_done got %b exp 0", pf_done); end
    checks++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL reset_wr_ready got %b exp 0", wr_ready); end
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL reset_rd_valid got %b exp 0", rd_valid); end
    checks++; if (rd_data !== 32'h0) begin errors++; $display("FAIL reset_rd_data got %h exp 0", rd_data); end
`ifdef DMA_BEAT_COUNT_EN
    checks++; if (beat_count !== 32'h0) begin errors++; $display("FAIL reset_beat_count got %0d exp 0", beat_count); end
`endif
    rst = 1'b0;
    $display("reset: outputs checked");
  endtask

  task automatic test_write_back();
    int beats, lat; bit held, cleared;
    for (int i = 0; i < 20; i++) wdata[i] = 32'h100 + i;
    do_write(32'd8, 19, beats, lat, held, cleared);
    checks++; if (beats != 20) begin errors++; $display("FAIL wb_ready_beats got %0d exp 20", beats); end
    checks++; if (lat != 23) begin errors++; $display("FAIL wb_done_latency got %0d exp 23", lat); end
    checks++; if (!held) begin errors++; $display("FAIL wb_done_held got 0 exp 1"); end
    checks++; if (!cleared) begin errors++; $display("FAIL wb_done_clear got 0 exp 1"); end
    $display("write addr=8 len=19 beats=%0d lat=%0d", beats, lat);
  endtask

  task automatic test_page_fault_single();
    int lat; bit held, cleared;
    do_read(32'd15, 0, lat, held, cleared);
    checks++; if (rq.size() != 1) begin errors++; $display("FAIL pf1_valid_count got %0d exp 1", rq.size()); end
    else begin
      checks++; if (rq[0] !== 32'h107) begin errors++; $display("FAIL pf1_data got %h exp 107", rq[0]); end
    end
    checks++; if (lat != 4) begin errors++; $display("FAIL pf1_done_latency got %0d exp 4", lat); end
    checks++; if (!held) begin errors++; $display("FAIL pf1_done_held got 0 exp 1"); end
    checks++; if (!cleared) begin errors++; $display("FAIL pf1_done_clear got 0 exp 1"); end
`ifdef DMA_BEAT_COUNT_EN
    checks++; if (beat_count !== 32'd21) begin errors++; $display("FAIL beat_count got %0d exp 21", beat_count); end
`endif
    $display("read addr=15 len=0 beats=%0d lat=%0d", rq.size(), lat);
  endtask

  task automatic test_simultaneous();
    int beats = 0, early = 0;
    for (int i = 0; i < 4; i++) wdata[i] = $urandom;
    rq.delete();
    @(negedge clk);
    wb_addr = 0; wb_len = 3; pf_addr = 0; pf_len = 3;
    wb_happen = 1'b1; pf_happen = 1'b1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (rd_valid || pf_done) early++;
      if (wb_done) break;
      wr_data = wdata[beats & 255];
      if (wr_ready) beats++;
    end
    checks++; if (wb_done !== 1'b1) begin errors++; $display("FAIL both_wb_done got %b exp 1", wb_done); end
    checks++; if (early != 0) begin errors++; $display("FAIL both_read_before_write got %0d exp 0", early); end
    checks++; if (beats != 4) begin errors++; $display("FAIL both_wb_beats got %0d exp 4", beats); end
    for (int i = 0; i < 4; i++) ref_mem[i] = wdata[i];
    wb_happen = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (rd_valid) rq.push_back(rd_data);
      if (pf_done) break;
    end
    checks++; if (rq.size() != 4) begin errors++; $display("FAIL both_rd_beats got %0d exp 4", rq.size()); end
    for (int i = 0; i < rq.size() && i < 4; i++) begin
      checks++;
      if (rq[i] !== ref_mem[i]) begin errors++; $display("FAIL both_rd_data[%0d] got %h exp %h", i, rq[i], ref_mem[i]); end
    end
    pf_happen = 1'b0;
    @(negedge clk);
    checks++; if (pf_done !== 1'b0 || wb_done !== 1'b0) begin errors++; $display("FAIL both_done_clear got %b%b exp 00", wb_done, pf_done); end
    $display("simultaneous write+read addr=0 len=3 rd_beats=%0d", rq.size());
  endtask

  task automatic test_wrap();
    int beats, lat; bit held, cleared;
    for (int i = 0; i < 4; i++) wdata[i] = $urandom;
    do_write(32'd1022, 3, beats, lat, held, cleared);
    checks++; if (lat != 7) begin errors++; $display("FAIL wrap_wb_latency got %0d exp 7", lat); end
    do_read(32'd1022, 3, lat, held, cleared);
    checks++; if (lat != 7) begin errors++; $display("FAIL wrap_pf_latency got %0d exp 7", lat); end
    checks++; if (rq.size() != 4) begin errors++; $display("FAIL wrap_rd_beats got %0d exp 4", rq.size()); end
    for (int i = 0; i < rq.size() && i < 4; i++) begin
      checks++;
      if (rq[i] !== ref_mem[(1022 + i) % 1024]) begin
        errors++; $display("FAIL wrap_rd_data[%0d] got %h exp %h", i, rq[i], ref_mem[(1022 + i) % 1024]);
      end
    end
    checks++; if (ref_mem[0] !== wdata[2] || rq.size() < 3 || rq[2] !== wdata[2]) begin
      errors++; $display("FAIL wrap_word0 got %h exp %h", (rq.size() > 2) ? rq[2] : 32'hx, wdata[2]);
    end
    $display("wrap write/read addr=1022 len=3 lat=%0d", lat);
  endtask

  task automatic test_random();
    int beats, lat, len; bit held, cleared; logic [31:0] a;
    for (int t = 0; t < 6; t++) begin
      a = $urandom;
      len = $urandom_range(0, 40);
      for (int i = 0; i <= len; i++) wdata[i] = $urandom;
      do_write(a, len, beats, lat, held, cleared);
      checks++; if (beats != len + 1 || lat != len + 4) begin
        errors++; $display("FAIL rand_wb[%0d] beats %0d lat %0d exp beats %0d lat %0d", t, beats, lat, len + 1, len + 4);
      end
      do_read(a, len, lat, held, cleared);
      checks++; if (rq.size() != len + 1 || lat != len + 4) begin
        errors++; $display("FAIL rand_pf[%0d] beats %0d lat %0d exp beats %0d lat %0d", t, rq.size(), lat, len + 1, len + 4);
      end
      for (int i = 0; i < rq.size() && i <= len; i++) begin
        checks++;
        if (rq[i] !== ref_mem[(a + i) % 1024]) begin
          errors++; $display("FAIL rand_rd_data[%0d][%0d] got %h exp %h", t, i, rq[i], ref_mem[(a + i) % 1024]);
        end
      end
      $display("random txn %0d addr=%0d len=%0d read_beats=%0d lat=%0d", t, a % 1024, len, rq.size(), lat);
    end
  endtask

  task automatic test_reset_mid_burst();
    int beats = 0, lat, stray = 0; bit held, cleared;
    for (int i = 0; i < 20; i++) wdata[i] = $urandom;
    @(negedge clk);
    wb_addr = 200; wb_len = 19; wb_happen = 1'b1;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (beats == 5) begin rst = 1'b1; break; end
      wr_data = wdata[beats];
      if (wr_ready) beats++;
    end
    @(negedge clk);
    checks++; if (wb_done !== 0 || wr_ready !== 0 || rd_valid !== 0 || rd_data !== 0 || pf_done !== 0) begin
      errors++; $display("FAIL midrst_outputs got done=%b rdy=%b val=%b data=%h exp all 0", wb_done, wr_ready, rd_valid, rd_data);
    end
`ifdef DMA_BEAT_COUNT_EN
    checks++; if (beat_count !== 32'h0) begin errors++; $display("FAIL midrst_beat_count got %0d exp 0", beat_count); end
`endif
    rst = 1'b0;
    wb_happen = 1'b0;
    repeat (6) begin @(negedge clk); if (wb_done || wr_ready) stray++; end
    checks++; if (stray != 0) begin errors++; $display("FAIL midrst_no_done got %0d exp 0", stray); end
    for (int i = 0; i < 4; i++) ref_mem[200 + i] = wdata[i];
    do_read(32'd200, 3, lat, held, cleared);
    checks++; if (lat != 7 || rq.size() != 4) begin errors++; $display("FAIL midrst_read got beats %0d lat %0d exp 4 7", rq.size(), lat); end
    for (int i = 0; i < rq.size() && i < 4; i++) begin
      checks++;
      if (rq[i] !== ref_mem[200 + i]) begin errors++; $display("FAIL midrst_kept[%0d] got %h exp %h", i, rq[i], ref_mem[200 + i]); end
    end
    for (int i = 0; i < 8; i++) wdata[i] = $urandom;
    do_write(32'd300, 7, beats, lat, held, cleared);
    checks++; if (lat != 11 || beats != 8) begin errors++; $display("FAIL midrst_new_write got beats %0d lat %0d exp 8 11", beats, lat); end
    $display("reset mid-burst then read len=3 and write len=7 lat=%0d", lat);
  endtask

  initial begin
    test_reset();
    test_write_back();
    test_page_fault_single();
    test_simultaneous();
    test_wrap();
    test_random();
    test_reset_mid_burst();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
